memory_arbiter: RTL

MEMORY_ARBITER -- requirements
Module: memory_arbiter

---
 rtl/memory_arbiter_pkg.sv | 22 ++
 rtl/arb_request_slot.sv | 41 ++++
 rtl/memory_arbiter.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/memory_arbiter_pkg.sv
// Shared memory-subsystem definitions: arbiter FSM encoding, requester indices,
// the data word returned on a watchdog timeout, and the request record.
package memory_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } arb_state_e;

  localparam logic P0 = 1'b0;
  localparam logic P1 = 1'b1;

  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] address;
    logic [2:0]  bhw;
    logic        write_notread;
  } mem_req_t;

endpackage

// File: rtl/arb_request_slot.sv
// One-deep request holding register for a single requester. A request is
// accepted only while the port is idle; anything arriving while busy is dropped.
module arb_request_slot
  import memory_arbiter_pkg::*;
(
  input  logic     i_clk,
  input  logic     i_rst_n,
  input  logic     capture_dv,
  input  mem_req_t req,
  input  logic     in_flight,
  input  logic     clear,
  output logic     pending,
  output logic     busy,
  output mem_req_t slot_req
);

  logic capture;

  assign busy    = pending | in_flight;
  assign capture = capture_dv & ~busy;

  // NOTE: reset is sampled on the clock edge only, and every register here uses
  // non-blocking assignment so all flops update together at the edge.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      pending  <= 1'b0;
      slot_req <= '0;
    end else begin
      // clear only occurs while this slot is in flight, so it never meets a capture
      if (clear) begin
        pending <= 1'b0;
      end else if (capture) begin
        pending <= 1'b1;
      end
      if (capture) begin
        slot_req <= req;
      end
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Two-port round-robin arbiter in front of a single-outstanding memory controller.
// Optional response watchdog is enabled by defining ARB_TIMEOUT_EN.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst_n,

  input  logic [31:0] i_p0_data,
  input  logic [31:0] i_p0_address,
  input  logic        i_p0_DV,
  input  logic [2:0]  i_p0_bhw,
  input  logic        i_p0_write_notread,
  output logic [31:0] o_p0_data,
  output logic        o_p0_DV,
  output logic        o_p0_busy,
  output logic        o_p0_err,

  input  logic [31:0] i_p1_data,
  input  logic [31:0] i_p1_address,
  input  logic        i_p1_DV,
  input  logic [2:0]  i_p1_bhw,
  input  logic        i_p1_write_notread,
  output logic [31:0] o_p1_data,
  output logic        o_p1_DV,
  output logic        o_p1_busy,
  output logic        o_p1_err,

  output logic [31:0] o_mem_data,
  output logic [31:0] o_mem_address,
  output logic        o_mem_DV,
  output logic [2:0]  o_mem_bhw,
  output logic        o_mem_write_notread,
  input  logic [31:0] i_mem_data,
  input  logic        i_mem_DV
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("memory_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  arb_state_e  state_q, state_d;
  logic        last_grant_q;
  logic        grant_q;
  logic        issue, issue_port, respond, timeout_hit;
  logic [1:0]  pending, in_flight, clear;
  mem_req_t    p0_req, p1_req, p0_slot, p1_slot, mem_q;
  logic [31:0] resp_data;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] tmo_cnt_q;
`endif

  assign p0_req = '{data: i_p0_data, address: i_p0_address,
                    bhw: i_p0_bhw, write_notread: i_p0_write_notread};
  assign p1_req = '{data: i_p1_data, address: i_p1_address,
                    bhw: i_p1_bhw, write_notread: i_p1_write_notread};

  assign in_flight[P0] = (state_q == WAIT) && (grant_q == P0);
  assign in_flight[P1] = (state_q == WAIT) && (grant_q == P1);
  assign clear[P0]     = (respond || timeout_hit) && (grant_q == P0);
  assign clear[P1]     = (respond || timeout_hit) && (grant_q == P1);

  arb_request_slot u_slot_p0 (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .capture_dv (i_p0_DV),
    .req        (p0_req),
    .in_flight  (in_flight[P0]),
    .clear      (clear[P0]),
    .pending    (pending[P0]),
    .busy       (o_p0_busy),
    .slot_req   (p0_slot)
  );

  arb_request_slot u_slot_p1 (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .capture_dv (i_p1_DV),
    .req        (p1_req),
    .in_flight  (in_flight[P1]),
    .clear      (clear[P1]),
    .pending    (pending[P1]),
    .busy       (o_p1_busy),
    .slot_req   (p1_slot)
  );

  // NOTE: every output of this block gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    issue       = 1'b0;
    issue_port  = P0;
    respond     = 1'b0;
    timeout_hit = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|pending) begin
          issue   = 1'b1;
          state_d = WAIT;
          // on a tie the port that did not win last time goes first
          if (&pending) begin
            issue_port = ~last_grant_q;
          end else begin
            issue_port = pending[P1];
          end
        end
      end
      WAIT: begin
        if (i_mem_DV) begin
          respond = 1'b1;
          state_d = IDLE;
        end
`ifdef ARB_TIMEOUT_EN
        else if (tmo_cnt_q == TMO_LAST) begin
          timeout_hit = 1'b1;
          state_d     = IDLE;
        end
`endif
      end
      default: ;
    endcase
  end

  assign resp_data = respond ? i_mem_data : TIMEOUT_DATA;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= P1;
      grant_q      <= P0;
      mem_q        <= '0;
      o_mem_DV     <= 1'b0;
      o_p0_data    <= '0;
      o_p1_data    <= '0;
      o_p0_DV      <= 1'b0;
      o_p1_DV      <= 1'b0;
    end else begin
      state_q  <= state_d;
      o_mem_DV <= issue;
      o_p0_DV  <= respond && (grant_q == P0);
      o_p1_DV  <= respond && (grant_q == P1);
      if (issue) begin
        last_grant_q <= issue_port;
        grant_q      <= issue_port;
        mem_q        <= (issue_port == P1) ? p1_slot : p0_slot;
      end
      if (clear[P0]) o_p0_data <= resp_data;
      if (clear[P1]) o_p1_data <= resp_data;
    end
  end

  assign o_mem_data          = mem_q.data;
  assign o_mem_address       = mem_q.address;
  assign o_mem_bhw           = mem_q.bhw;
  assign o_mem_write_notread = mem_q.write_notread;

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      tmo_cnt_q <= '0;
      o_p0_err  <= 1'b0;
      o_p1_err  <= 1'b0;
    end else begin
      // counts cycles spent in WAIT, restarting at 0 on every new issue
      if ((state_q == WAIT) && (state_d == WAIT)) begin
        tmo_cnt_q <= tmo_cnt_q + 1'b1;
      end else begin
        tmo_cnt_q <= '0;
      end
      o_p0_err <= timeout_hit && (grant_q == P0);
      o_p1_err <= timeout_hit && (grant_q == P1);
    end
  end
`else
  assign o_p0_err = 1'b0;
  assign o_p1_err = 1'b0;
`endif

endmodule
